param_up_down_counter: RTL and testbench

Parametrised synchronous up/down counter. It generalises the team's fixed 3-bit up/down counter in four ways: configurable width and modulus, a synchronous parallel load, a count enable, and a selectable wrap or saturate policy. It also reports terminal-count and overflow events. It serves as the common counter primitive for the lab timing and sequencing blocks.

---
 rtl/param_up_down_counter.sv | 88 ++++++++
 tb/tb_param_up_down_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with synchronous load, count enable, wrap or
// saturate policy, terminal-count look-ahead and sticky event flags.
module param_up_down_counter #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             carry,
  output logic             overflow,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);

  logic             at_max_s;
  logic             at_zero_s;
  logic             event_s;
  logic             load_oor_s;
  logic [WIDTH-1:0] next_q_s;

  assign at_max_s  = (q == MAX_VAL);
  assign at_zero_s = (q == ZERO_VAL);
  assign tc        = enable & ~load & ((mode & at_max_s) | (~mode & at_zero_s));
  assign qbar      = ~q;

  // Next-count selection: load beats enable, range ends wrap or hold.
  always_comb begin
    next_q_s   = q;
    event_s    = 1'b0;
    load_oor_s = 1'b0;
    if (load) begin
      if ({1'b0, load_value} < MOD_EXT) begin
        next_q_s = load_value;
      end else begin
        next_q_s   = MAX_VAL;
        load_oor_s = 1'b1;
      end
    end else if (enable) begin
      if (mode) begin
        if (at_max_s) begin
          event_s  = 1'b1;
          next_q_s = (SATURATE != 0) ? q : ZERO_VAL;
        end else begin
          next_q_s = q + ONE_VAL;
        end
      end else begin
        if (at_zero_s) begin
          event_s  = 1'b1;
          next_q_s = (SATURATE != 0) ? q : MAX_VAL;
        end else begin
          next_q_s = q - ONE_VAL;
        end
      end
    end else begin
      next_q_s = q;
    end
  end

  // State and flag registers; a new event on the same edge beats clear_flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q        <= ZERO_VAL;
      carry    <= 1'b0;
      overflow <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= next_q_s;
      carry    <= event_s;
      overflow <= event_s | (overflow & ~clear_flags);
      load_err <= load_oor_s | (load_err & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Bench for param_up_down_counter: three configurations share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_param_up_down_counter;

  localparam int N = 3;

  logic       clock = 1'b0;
  logic       clear, enable, mode, load, clear_flags;
  logic [3:0] load_value;

  logic [2:0] q_a, qbar_a, q_b, qbar_b;
  logic [3:0] q_c, qbar_c;
  logic       tc_a, carry_a, overflow_a, load_err_a;
  logic       tc_b, carry_b, overflow_b, load_err_b;
  logic       tc_c, carry_c, overflow_c, load_err_c;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  // Instance a: 3 bits, modulus 6, wrap. b: same, saturate. c: 4 bits, modulus 16, wrap.
  param_up_down_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) dut_a (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value[2:0]), .clear_flags(clear_flags), .q(q_a), .qbar(qbar_a),
    .tc(tc_a), .carry(carry_a), .overflow(overflow_a), .load_err(load_err_a));

  param_up_down_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) dut_b (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value[2:0]), .clear_flags(clear_flags), .q(q_b), .qbar(qbar_b),
    .tc(tc_b), .carry(carry_b), .overflow(overflow_b), .load_err(load_err_b));

  param_up_down_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_c (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .clear_flags(clear_flags), .q(q_c), .qbar(qbar_c),
    .tc(tc_c), .carry(carry_c), .overflow(overflow_c), .load_err(load_err_c));

  always #5 clock = ~clock;

  int modv[N] = '{6, 6, 16};
  bit satv[N] = '{1'b0, 1'b1, 1'b0};
  int wv[N]   = '{3, 3, 4};

  int mq[N]    = '{0, 0, 0};
  int mcar[N]  = '{0, 0, 0};
  int movf[N]  = '{0, 0, 0};
  int mlerr[N] = '{0, 0, 0};

  // Reference model: one step of the counting rules per rising edge.
  always @(posedge clock or posedge clear) begin
    for (int i = 0; i < N; i++) begin
      if (clear) begin
        mq[i] <= 0; mcar[i] <= 0; movf[i] <= 0; mlerr[i] <= 0;
      end else begin
        automatic int lv  = int'(load_value) % (1 << wv[i]);
        automatic int nq  = mq[i];
        automatic int ev  = 0;
        automatic int bad = 0;
        if (load) begin
          if (lv < modv[i]) nq = lv;
          else begin nq = modv[i] - 1; bad = 1; end
        end else if (enable && mode) begin
          if (mq[i] == modv[i] - 1) begin ev = 1; nq = satv[i] ? mq[i] : 0; end
          else nq = mq[i] + 1;
        end else if (enable) begin
          if (mq[i] == 0) begin ev = 1; nq = satv[i] ? 0 : modv[i] - 1; end
          else nq = mq[i] - 1;
        end
        mq[i]    <= nq;
        mcar[i]  <= ev;
        movf[i]  <= (ev != 0 || (movf[i] != 0 && !clear_flags)) ? 1 : 0;
        mlerr[i] <= (bad != 0 || (mlerr[i] != 0 && !clear_flags)) ? 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic [3:0] dq[N], dqb[N];
  logic       dtc[N], dcar[N], dovf[N], dlerr[N];
  assign dq[0] = {1'b0, q_a};  assign dqb[0] = {1'b0, qbar_a};
  assign dq[1] = {1'b0, q_b};  assign dqb[1] = {1'b0, qbar_b};
  assign dq[2] = q_c;          assign dqb[2] = qbar_c;
  assign dtc[0] = tc_a; assign dcar[0] = carry_a; assign dovf[0] = overflow_a; assign dlerr[0] = load_err_a;
  assign dtc[1] = tc_b; assign dcar[1] = carry_b; assign dovf[1] = overflow_b; assign dlerr[1] = load_err_b;
  assign dtc[2] = tc_c; assign dcar[2] = carry_c; assign dovf[2] = overflow_c; assign dlerr[2] = load_err_c;

  // Every-cycle comparison of all instances against the model, away from the edge.
  always @(negedge clock) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        automatic int etc = (enable && !load &&
                             ((mode && mq[i] == modv[i] - 1) || (!mode && mq[i] == 0))) ? 1 : 0;
        chk($sformatf("model_q[%0d]", i), 32'(dq[i]), mq[i]);
        chk($sformatf("model_qbar[%0d]", i), 32'(dqb[i]), (~mq[i]) & ((1 << wv[i]) - 1));
        chk($sformatf("model_tc[%0d]", i), 32'(dtc[i]), etc);
        chk($sformatf("model_carry[%0d]", i), 32'(dcar[i]), mcar[i]);
        chk($sformatf("model_overflow[%0d]", i), 32'(dovf[i]), movf[i]);
        chk($sformatf("model_load_err[%0d]", i), 32'(dlerr[i]), mlerr[i]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int up_q[8]   = '{1, 2, 3, 4, 5, 0, 1, 2};
  int dn_qb[4]  = '{1, 0, 0, 0};
  int dn_cb[4]  = '{0, 0, 1, 1};
  int dn_qa[4]  = '{1, 0, 5, 4};

  initial begin
    clear = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0;
    clear_flags = 1'b0; load_value = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    armed = 1'b1;

    // Up count with wrap on a, saturate on b, free run on c.
    enable = 1'b1; mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("up_q_a", 32'(q_a), up_q[k]);
      chk("up_tc_a", 32'(tc_a), (k == 4) ? 1 : 0);
      chk("up_carry_a", 32'(carry_a), (k == 5) ? 1 : 0);
      chk("up_overflow_a", 32'(overflow_a), (k >= 5) ? 1 : 0);
    end
    chk("up_q_b_sat", 32'(q_b), 5);
    chk("up_q_c", 32'(q_c), 8);

    // Asynchronous clear mid-count, no clock edge involved.
    #2;
    clear = 1'b1;
    #1;
    chk("rst_q_a", 32'(q_a), 0);
    chk("rst_qbar_a", 32'(qbar_a), 7);
    chk("rst_carry_a", 32'(carry_a), 0);
    chk("rst_overflow_a", 32'(overflow_a), 0);
    chk("rst_load_err_a", 32'(load_err_a), 0);
    chk("rst_qbar_c", 32'(qbar_c), 15);
    step();
    clear = 1'b0;
    step();
    chk("resume_q_a", 32'(q_a), 1);
    enable = 1'b0;

    // Load 2 then count down: b saturates at 0, a wraps to 5.
    load = 1'b1; load_value = 4'd2;
    step();
    chk("load2_q_b", 32'(q_b), 2);
    load = 1'b0; enable = 1'b1; mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dn_q_b", 32'(q_b), dn_qb[k]);
      chk("dn_carry_b", 32'(carry_b), dn_cb[k]);
      chk("dn_q_a", 32'(q_a), dn_qa[k]);
    end
    chk("dn_overflow_b", 32'(overflow_b), 1);

    // Load beats an enabled down count at zero on b.
    load = 1'b1; load_value = 4'd4;
    step();
    chk("ld_q_a", 32'(q_a), 4);
    chk("ld_q_b", 32'(q_b), 4);
    chk("ld_carry_b", 32'(carry_b), 0);
    load_value = 4'd7;
    step();
    chk("ldoor_q_a", 32'(q_a), 5);
    chk("ldoor_err_a", 32'(load_err_a), 1);
    chk("ld7_q_c", 32'(q_c), 7);
    chk("ld7_err_c", 32'(load_err_c), 0);
    load = 1'b0; enable = 1'b0;

    // clear_flags alone clears; with a coincident wrap the set wins.
    clear_flags = 1'b1;
    step();
    chk("cf_overflow_a", 32'(overflow_a), 0);
    chk("cf_load_err_a", 32'(load_err_a), 0);
    enable = 1'b1; mode = 1'b1;
    step();
    chk("cfwrap_q_a", 32'(q_a), 0);
    chk("cfwrap_overflow_a", 32'(overflow_a), 1);
    chk("cfwrap_carry_a", 32'(carry_a), 1);
    chk("cfsat_q_b", 32'(q_b), 5);
    clear_flags = 1'b0; enable = 1'b0;

    // Full-width direction reversal on c.
    load = 1'b1; load_value = 4'd14;
    step();
    chk("rev_load_c", 32'(q_c), 14);
    load = 1'b0; enable = 1'b1; mode = 1'b1;
    step();
    chk("rev_q_c_15", 32'(q_c), 15);
    chk("rev_tc_c", 32'(tc_c), 1);
    chk("rev_carry_c_15", 32'(carry_c), 0);
    step();
    chk("rev_q_c_0", 32'(q_c), 0);
    chk("rev_carry_c_0", 32'(carry_c), 1);
    mode = 1'b0;
    step();
    chk("rev_q_c_15b", 32'(q_c), 15);
    chk("rev_carry_c_15b", 32'(carry_c), 1);
    step();
    chk("rev_q_c_14", 32'(q_c), 14);
    chk("rev_carry_c_14", 32'(carry_c), 0);
    step();
    chk("rev_q_c_13", 32'(q_c), 13);
    enable = 1'b0;

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
